// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: resolves ALU operands and holds them in a single-entry
// valid/ready pipeline register. Optional forwarding: `define OSYRYS64_OPERAND_FWD_EN.
module alu_operand_stage #(
   parameter int XLEN   = 64,
   parameter int RA_W   = 5,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [RA_W-1:0]   in_rs1_addr,
   input  logic [RA_W-1:0]   in_rs2_addr,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   input  logic [XLEN-1:0]   in_imm,
   input  logic              in_src1_pc,
   input  logic              in_src2_imm,
   input  logic [CTRL_W-1:0] in_alu_control,
   input  logic [RA_W-1:0]   in_rd_addr,
   input  logic              in_rd_we,
   input  logic              flush,
   input  logic              ex_fwd_valid,
   input  logic [RA_W-1:0]   ex_fwd_rd,
   input  logic [XLEN-1:0]   ex_fwd_data,
   input  logic              wb_fwd_valid,
   input  logic [RA_W-1:0]   wb_fwd_rd,
   input  logic [XLEN-1:0]   wb_fwd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   src1,
   output logic [XLEN-1:0]   src2,
   output logic [CTRL_W-1:0] alu_control,
   output logic [XLEN-1:0]   out_store_data,
   output logic [RA_W-1:0]   out_rd_addr,
   output logic              out_rd_we,
   output logic [XLEN-1:0]   out_pc
);

   logic              out_valid_reg;
   logic [XLEN-1:0]   src1_reg, src2_reg, store_data_reg, pc_reg;
   logic [CTRL_W-1:0] alu_control_reg;
   logic [RA_W-1:0]   rd_addr_reg;
   logic              rd_we_reg;

   logic [XLEN-1:0]   rs1_val, rs2_val, src1_next, src2_next;
   logic              hazard;
   logic              ex_hit1, ex_hit2, wb_hit1, wb_hit2;
   logic              in_ready_int, accept;

   // x0 is hard-wired zero, so it never matches a producer.
   assign ex_hit1 = ex_fwd_valid && (ex_fwd_rd != '0) && (in_rs1_addr == ex_fwd_rd);
   assign ex_hit2 = ex_fwd_valid && (ex_fwd_rd != '0) && (in_rs2_addr == ex_fwd_rd);
   assign wb_hit1 = wb_fwd_valid && (wb_fwd_rd != '0) && (in_rs1_addr == wb_fwd_rd);
   assign wb_hit2 = wb_fwd_valid && (wb_fwd_rd != '0) && (in_rs2_addr == wb_fwd_rd);

`ifdef OSYRYS64_OPERAND_FWD_EN
   // EX holds the younger result, so it wins over WB.
   always_comb begin
      rs1_val = in_rs1_data;
      rs2_val = in_rs2_data;
      if (ex_hit1)
         rs1_val = ex_fwd_data;
      else if (wb_hit1)
         rs1_val = wb_fwd_data;
      if (ex_hit2)
         rs2_val = ex_fwd_data;
      else if (wb_hit2)
         rs2_val = wb_fwd_data;
   end
   assign hazard = 1'b0;
`else
   logic unused_fwd_data;
   assign unused_fwd_data = ^{ex_fwd_data, wb_fwd_data};
   assign rs1_val = in_rs1_data;
   assign rs2_val = in_rs2_data;
   // No store indication reaches this stage, so rs2 counts as used only as an ALU source.
   assign hazard  = (!in_src1_pc  && (ex_hit1 || wb_hit1)) ||
                    (!in_src2_imm && (ex_hit2 || wb_hit2));
`endif

   assign src1_next    = in_src1_pc  ? in_pc  : rs1_val;
   assign src2_next    = in_src2_imm ? in_imm : rs2_val;
   // A flushed instruction is dropped anyway, so a pending hazard must not block it.
   assign in_ready_int = (!out_valid_reg || out_ready) && (flush || !hazard);
   assign accept       = in_valid && in_ready_int;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg   <= 1'b0;
         src1_reg        <= '0;
         src2_reg        <= '0;
         store_data_reg  <= '0;
         pc_reg          <= '0;
         alu_control_reg <= '0;
         rd_addr_reg     <= '0;
         rd_we_reg       <= 1'b0;
      end else if (flush) begin
         out_valid_reg <= 1'b0;
      end else if (accept) begin
         out_valid_reg   <= 1'b1;
         src1_reg        <= src1_next;
         src2_reg        <= src2_next;
         store_data_reg  <= rs2_val;
         pc_reg          <= in_pc;
         alu_control_reg <= in_alu_control;
         rd_addr_reg     <= in_rd_addr;
         rd_we_reg       <= in_rd_we;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign in_ready       = in_ready_int;
   assign out_valid      = out_valid_reg;
   assign src1           = src1_reg;
   assign src2           = src2_reg;
   assign alu_control    = alu_control_reg;
   assign out_store_data = store_data_reg;
   assign out_rd_addr    = rd_addr_reg;
   assign out_rd_we      = rd_we_reg;
   assign out_pc         = pc_reg;

endmodule
